// File: rtl/cyclic_prefix_inserter_pkg.sv
// Shared OFDM symbol geometry, CP FSM states and the packed-symbol builder.
// The RX CP-removal side and scoreboards reuse cp_pack so both ends agree bit-for-bit.
package ofdm_pkg;

  localparam int N       = 8;
  localparam int W       = 16;
  localparam int CP_LEN  = 3;
  localparam int FRAME_W = 2 * N * W;
  localparam int NWORDS  = 2 * N + CP_LEN;
  localparam int SYM_W   = NWORDS * W;
  localparam int K_W     = $clog2(NWORDS);

  typedef enum logic [1:0] {
    IDLE,
    SEND_CP,
    SEND_BODY
  } cp_state_t;

  // Prefix is the lowest CP_LEN words of the frame, placed above the frame.
  function automatic logic [SYM_W-1:0] cp_pack(input logic [FRAME_W-1:0] frame);
    return {frame[CP_LEN*W-1:0], frame};
  endfunction

endpackage

// File: rtl/cyclic_prefix_inserter_if.sv
// Symbol-in / packed-symbol-out / serial-word-out bundle of the CP inserter.
// slave is the inserter's view, master is the IFFT source plus downstream sink.
interface cyclic_prefix_inserter_if;
  import ofdm_pkg::*;

  logic [N*W-1:0]   I_IFFT;
  logic [N*W-1:0]   Q_IFFT;
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] symbol_out;
  logic             sym_valid;
  logic [W-1:0]     out_word;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  I_IFFT, Q_IFFT, in_valid, out_ready,
    output in_ready, symbol_out, sym_valid, out_word, out_valid, out_last
  );

  modport master (
    output I_IFFT, Q_IFFT, in_valid, out_ready,
    input  in_ready, symbol_out, sym_valid, out_word, out_valid, out_last
  );

endinterface

// File: rtl/cyclic_prefix_inserter_serializer.sv
// Walks the packed symbol MSB word first; k advances only on a handshake, so the
// word and last flag hold while downstream stalls.
module cp_word_serializer
  import ofdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             active_i,
  input  logic [SYM_W-1:0] symbol_i,
  input  logic             ready_i,
  output logic [W-1:0]     word_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             cp_done_o,
  output logic             last_hs_o
);

  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_d;
  logic           hs;

  assign valid_o   = active_i;
  assign hs        = active_i && ready_i;
  assign last_o    = active_i && (k_q == K_W'(NWORDS - 1));
  assign cp_done_o = hs && (k_q == K_W'(CP_LEN - 1));
  assign last_hs_o = hs && last_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  always_comb begin
    k_d = k_q;
    if (hs) begin
      k_d = last_o ? '0 : k_q + 1'b1;
    end
  end

  // Word mux; idle output is forced to zero so a dropped symbol leaves no residue.
  always_comb begin
    word_o = '0;
    if (active_i) begin
      for (int j = 0; j < NWORDS; j++) begin
        if (k_q == K_W'(j)) begin
          word_o = symbol_i[SYM_W-1-j*W -: W];
        end
      end
    end
  end

endmodule

// File: rtl/cyclic_prefix_inserter.sv
// Captures one IFFT symbol, prepends the cyclic prefix and emits it packed and as a word stream.
// First word one cycle after capture; a new symbol is taken in the same cycle as the previous last word.
module cyclic_prefix_inserter
  import ofdm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  cyclic_prefix_inserter_if.slave  cp_if
);

  cp_state_t        state_q;
  cp_state_t        state_d;
  logic [SYM_W-1:0] sym_q;
  logic             sym_vld_q;
  logic             active;
  logic             in_ready;
  logic             capture;
  logic             cp_done;
  logic             last_hs;
  logic [W-1:0]     word;
  logic             word_vld;
  logic             word_last;

  assign capture = cp_if.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (capture) state_d = SEND_CP;
      SEND_CP:   if (cp_done) state_d = SEND_BODY;
      SEND_BODY: if (last_hs) state_d = capture ? SEND_CP : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // in_ready reaches back through last_hs to out_ready so symbols chain without a bubble.
  always_comb begin
    active   = (state_q != IDLE);
    in_ready = (state_q == IDLE) || last_hs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q     <= '0;
      sym_vld_q <= 1'b0;
    end else begin
      sym_vld_q <= capture;
      if (capture) begin
        sym_q <= cp_pack({cp_if.I_IFFT, cp_if.Q_IFFT});
      end
    end
  end

  cp_word_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .active_i  (active),
    .symbol_i  (sym_q),
    .ready_i   (cp_if.out_ready),
    .word_o    (word),
    .valid_o   (word_vld),
    .last_o    (word_last),
    .cp_done_o (cp_done),
    .last_hs_o (last_hs)
  );

  assign cp_if.in_ready   = in_ready;
  assign cp_if.symbol_out = sym_q;
  assign cp_if.sym_valid  = sym_vld_q;
  assign cp_if.out_word   = word;
  assign cp_if.out_valid  = word_vld;
  assign cp_if.out_last   = word_last;

endmodule
